epsilon_serializer: RTL and testbench

EPSILON_SERIALIZER -- requirements
Module: epsilon_serializer

---
 rtl/epsilon_serializer_if.sv | 23 ++
 rtl/epsilon_serializer.sv | 189 ++++++++++++++++++
 tb/tb_epsilon_serializer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/epsilon_serializer_if.sv
// Byte-in / bit-out bus between a byte source and the epsilon serializer.
//   byte_dat/byte_vld/byte_rdy : byte handshake, transfer when vld && rdy on clk rise
//   epsilon_rsc_dat            : serialized frame bit
//   epsilon_vld                : epsilon_rsc_dat carries a frame bit
//   epsilon_triosy_lz          : pulse coincident with the last bit of a frame
interface epsilon_serializer_if;
    logic [7:0] byte_dat;
    logic       byte_vld;
    logic       byte_rdy;
    logic       epsilon_rsc_dat;
    logic       epsilon_vld;
    logic       epsilon_triosy_lz;

    modport master (
        output byte_dat, byte_vld,
        input  byte_rdy, epsilon_rsc_dat, epsilon_vld, epsilon_triosy_lz
    );

    modport slave (
        input  byte_dat, byte_vld,
        output byte_rdy, epsilon_rsc_dat, epsilon_vld, epsilon_triosy_lz
    );
endinterface

// File: rtl/epsilon_serializer.sv
// Epsilon serializer: buffers source bytes in a small FIFO and emits a frame
// of FRAME_BITS bits, LSB first, toward a monobit tester.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : begin a frame (sampled only in IDLE)
//   bus (slave)   : byte handshake in, epsilon bit stream out
//   busy          : FSM not in IDLE
//   underrun      : sticky, a SHIFT cycle found no bit available
//   bit_count     : frame bits emitted in the current frame
// Optional feature: define EPSILON_PRNG_FILL_EN to fill starved cycles with
// bits from a 16-bit Fibonacci LFSR instead of stalling.
module epsilon_serializer #(
    parameter int unsigned FRAME_BITS = 128,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    epsilon_serializer_if.slave  bus,
    output logic                 busy,
    output logic                 underrun,
    output logic [15:0]          bit_count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               byte_rdy_q, byte_rdy_d;
    logic [7:0]         sh_data_q, sh_data_d;
    logic [3:0]         sh_cnt_q, sh_cnt_d;
    logic [15:0]        bit_count_q, bit_count_d;
    logic               underrun_q, underrun_d;
    logic               busy_q, busy_d;
    logic               dat_q, dat_d;
    logic               vld_q, vld_d;
    logic               lz_q, lz_d;
    logic               push, pop, emit, fifo_empty, last_bit;
`ifdef EPSILON_PRNG_FILL_EN
    logic [15:0]        lfsr_q, lfsr_d;
`endif

    assign push       = bus.byte_vld & byte_rdy_q;
    assign fifo_empty = (count_q == '0);
    assign last_bit   = (bit_count_q == 16'(FRAME_BITS - 1));

    // Next-state, shifter, FIFO pointer and output decode
    always_comb begin
        state_d     = state_q;
        sh_data_d   = sh_data_q;
        sh_cnt_d    = sh_cnt_q;
        bit_count_d = bit_count_q;
        underrun_d  = underrun_q;
        dat_d       = 1'b0;
        vld_d       = 1'b0;
        lz_d        = 1'b0;
        pop         = 1'b0;
        emit        = 1'b0;
`ifdef EPSILON_PRNG_FILL_EN
        lfsr_d      = lfsr_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SHIFT;
                    bit_count_d = 16'd0;
                    underrun_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (sh_cnt_q != 4'd0) begin
                    emit      = 1'b1;
                    dat_d     = sh_data_q[0];
                    sh_data_d = {1'b0, sh_data_q[7:1]};
                    sh_cnt_d  = sh_cnt_q - 4'd1;
                    // Reload behind the last shifter bit so bytes run back to back
                    if (sh_cnt_q == 4'd1 && !fifo_empty && !last_bit) begin
                        pop       = 1'b1;
                        sh_data_d = mem_q[rd_ptr_q];
                        sh_cnt_d  = 4'd8;
                    end
                end else if (!fifo_empty) begin
                    pop       = 1'b1;
                    sh_data_d = mem_q[rd_ptr_q];
                    sh_cnt_d  = 4'd8;
                end else begin
                    underrun_d = 1'b1;
`ifdef EPSILON_PRNG_FILL_EN
                    emit   = 1'b1;
                    dat_d  = lfsr_q[0];
                    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
`endif
                end

                if (emit) begin
                    vld_d       = 1'b1;
                    bit_count_d = bit_count_q + 16'd1;
                    // Frame end: residual shifter bits are dropped, FIFO kept
                    if (last_bit) begin
                        lz_d     = 1'b1;
                        state_d  = DONE;
                        sh_cnt_d = 4'd0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; ready tracks registered occupancy only
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        byte_rdy_d = (count_d < CNT_W'(FIFO_DEPTH));
        busy_d     = (state_d != IDLE);
    end

    // State and control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            byte_rdy_q  <= 1'b1;
            sh_data_q   <= 8'd0;
            sh_cnt_q    <= 4'd0;
            bit_count_q <= 16'd0;
            underrun_q  <= 1'b0;
            busy_q      <= 1'b0;
            dat_q       <= 1'b0;
            vld_q       <= 1'b0;
            lz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            byte_rdy_q  <= byte_rdy_d;
            sh_data_q   <= sh_data_d;
            sh_cnt_q    <= sh_cnt_d;
            bit_count_q <= bit_count_d;
            underrun_q  <= underrun_d;
            busy_q      <= busy_d;
            dat_q       <= dat_d;
            vld_q       <= vld_d;
            lz_q        <= lz_d;
        end
    end

`ifdef EPSILON_PRNG_FILL_EN
    // Fill generator, advances only when it supplies a bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end
`endif

    // FIFO storage; contents are don't-care while unoccupied
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.byte_dat;
    end

    assign bus.byte_rdy          = byte_rdy_q;
    assign bus.epsilon_rsc_dat   = dat_q;
    assign bus.epsilon_vld       = vld_q;
    assign bus.epsilon_triosy_lz = lz_q;
    assign busy                  = busy_q;
    assign underrun              = underrun_q;
    assign bit_count             = bit_count_q;

endmodule

// File: tb/tb_epsilon_serializer.sv
// Directed bench for epsilon_serializer (FRAME_BITS=128, FIFO_DEPTH=4).
module tb_epsilon_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        underrun;
    logic [15:0] bit_count;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    epsilon_serializer_if bus ();

    epsilon_serializer #(.FRAME_BITS(128), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus.slave),
        .busy      (busy),
        .underrun  (underrun),
        .bit_count (bit_count)
    );

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        bus.byte_vld = 1'b0;
        bus.byte_dat = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        bus.byte_dat = b;
        bus.byte_vld = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (bus.byte_rdy) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.byte_vld = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests++; if (bus.epsilon_vld !== 1'b0) begin fails++; $display("FAIL reset_vld: got %b want 0", bus.epsilon_vld); end
        tests++; if (bus.epsilon_rsc_dat !== 1'b0) begin fails++; $display("FAIL reset_dat: got %b want 0", bus.epsilon_rsc_dat); end
        tests++; if (bus.epsilon_triosy_lz !== 1'b0) begin fails++; $display("FAIL reset_lz: got %b want 0", bus.epsilon_triosy_lz); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        tests++; if (bit_count !== 16'd0) begin fails++; $display("FAIL reset_bit_count: got %0d want 0", bit_count); end
        tests++; if (bus.byte_rdy !== 1'b1) begin fails++; $display("FAIL reset_byte_rdy: got %b want 1", bus.byte_rdy); end
    endtask

    // Stream 16 x 8'hFF while a frame runs; optionally reset at bit abort_at.
    task automatic run_ones_frame(input int abort_at);
        int pushed = 0;
        int got = 0;
        int ones = 0;
        int lz_n = 0;
        int lz_at = 0;
        int gaps = 0;
        bit started = 1'b0;
        bit aborted = 1'b0;
        do_reset();
        fork
            begin
                bus.byte_dat = 8'hFF;
                bus.byte_vld = 1'b1;
                for (int c = 0; c < 3000 && pushed < 16 && !aborted; c++) begin
                    @(negedge clk);
                    if (bus.byte_rdy && !aborted) begin
                        @(posedge clk);
                        pushed++;
                        #1;
                    end
                end
                bus.byte_vld = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                pulse_start();
                for (int c = 0; c < 400; c++) begin
                    @(negedge clk);
                    if (started && !bus.epsilon_vld) gaps++;
                    if (bus.epsilon_vld) begin
                        started = 1'b1;
                        got++;
                        if (bus.epsilon_rsc_dat) ones++;
                        if (bus.epsilon_triosy_lz) begin lz_n++; lz_at = got; end
                    end
                    if (abort_at != 0 && got == abort_at) begin
                        tests++; if (bit_count !== 16'(abort_at)) begin fails++; $display("FAIL abort_count: got %0d want %0d", bit_count, abort_at); end
                        #2 rst = 1'b1;
                        aborted = 1'b1;
                        #1;
                        tests++; if (bus.epsilon_vld !== 1'b0) begin fails++; $display("FAIL abort_vld: got %b want 0", bus.epsilon_vld); end
                        tests++; if (bus.epsilon_rsc_dat !== 1'b0) begin fails++; $display("FAIL abort_dat: got %b want 0", bus.epsilon_rsc_dat); end
                        tests++; if (bus.epsilon_triosy_lz !== 1'b0) begin fails++; $display("FAIL abort_lz: got %b want 0", bus.epsilon_triosy_lz); end
                        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
                        tests++; if (bit_count !== 16'd0) begin fails++; $display("FAIL abort_bit_count: got %0d want 0", bit_count); end
                        @(negedge clk) rst = 1'b0;
                        break;
                    end
                    if (lz_n != 0) break;
                end
            end
        join

        if (abort_at != 0) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (bus.epsilon_triosy_lz) lz_n++;
            end
            tests++; if (lz_n !== 0) begin fails++; $display("FAIL abort_no_pulse: got %0d pulses want 0", lz_n); end
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_idle: got busy %b want 0", busy); end
        end else begin
            tests++; if (got !== 128) begin fails++; $display("FAIL ones_bits: got %0d want 128", got); end
            tests++; if (ones !== 128) begin fails++; $display("FAIL ones_value: got %0d ones want 128", ones); end
            tests++; if (gaps !== 0) begin fails++; $display("FAIL ones_gaps: got %0d want 0", gaps); end
            tests++; if (lz_n !== 1 || lz_at !== 128) begin fails++; $display("FAIL ones_lz: got %0d pulses at bit %0d want 1 at 128", lz_n, lz_at); end
            tests++; if (bit_count !== 16'd128) begin fails++; $display("FAIL ones_bit_count: got %0d want 128", bit_count); end
            tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL ones_underrun: got %b want 0", underrun); end
            @(negedge clk);
            tests++; if (busy !== 1'b0 || bus.epsilon_vld !== 1'b0) begin fails++; $display("FAIL ones_done_idle: got busy %b vld %b want 0 0", busy, bus.epsilon_vld); end
            tests++; if (bit_count !== 16'd128) begin fails++; $display("FAIL ones_count_hold: got %0d want 128", bit_count); end
        end
    endtask

    task automatic test_all_ones();
        run_ones_frame(0);
    endtask

    task automatic test_pattern();
        logic [15:0] bits = 16'h0000;
        int n = 0;
        int first = -1;
        int last = -1;
        do_reset();
        push_byte(8'hA5);
        push_byte(8'h3C);
        pulse_start();
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.epsilon_vld) begin
                bits[n] = bus.epsilon_rsc_dat;
                if (n == 0) first = c;
                n++;
                if (n == 16) begin last = c; break; end
            end
        end
        tests++; if (bits !== 16'h3CA5) begin fails++; $display("FAIL pattern_bits: got %h want 3ca5", bits); end
        tests++; if (last - first !== 15) begin fails++; $display("FAIL pattern_gap: got span %0d want 15", last - first); end
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL pattern_no_underrun: got %b want 0", underrun); end
        @(negedge clk);
        tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL pattern_underrun_after: got %b want 1", underrun); end
    endtask

    task automatic test_underrun();
        logic [7:0] val = 8'h00;
        int nv = 0;
        logic [2:0] fill = 3'b000;
        do_reset();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 1) begin
`ifdef EPSILON_PRNG_FILL_EN
                tests++; if (bus.epsilon_vld !== 1'b1) begin fails++; $display("FAIL stall_vld[%0d]: got %b want 1", i, bus.epsilon_vld); end
                if (i <= 3) fill[i-1] = bus.epsilon_rsc_dat;
`else
                tests++; if (bus.epsilon_vld !== 1'b0) begin fails++; $display("FAIL stall_vld[%0d]: got %b want 0", i, bus.epsilon_vld); end
`endif
            end
        end
        tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL stall_underrun: got %b want 1", underrun); end
`ifdef EPSILON_PRNG_FILL_EN
        tests++; if (fill !== 3'b001) begin fails++; $display("FAIL stall_lfsr_bits: got %b want 001", fill); end
`endif
        push_byte(8'h81);
        @(negedge clk);
`ifdef EPSILON_PRNG_FILL_EN
        tests++; if (bus.epsilon_vld !== 1'b1) begin fails++; $display("FAIL resume_pre: got %b want 1", bus.epsilon_vld); end
`else
        tests++; if (bus.epsilon_vld !== 1'b0) begin fails++; $display("FAIL resume_pre: got %b want 0", bus.epsilon_vld); end
`endif
        @(negedge clk);
        tests++; if (bus.epsilon_vld !== 1'b0) begin fails++; $display("FAIL resume_load: got %b want 0", bus.epsilon_vld); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.epsilon_vld) nv++;
            val[i] = bus.epsilon_rsc_dat;
        end
        tests++; if (nv !== 8) begin fails++; $display("FAIL resume_vld: got %0d want 8", nv); end
        tests++; if (val !== 8'h81) begin fails++; $display("FAIL resume_bits: got %h want 81", val); end
`ifndef EPSILON_PRNG_FILL_EN
        tests++; if (bit_count !== 16'd8) begin fails++; $display("FAIL resume_bit_count: got %0d want 8", bit_count); end
`endif
        tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL resume_sticky: got %b want 1", underrun); end
    endtask

    task automatic test_fifo_full();
        int acc = 0;
        do_reset();
        @(negedge clk);
        bus.byte_dat = 8'h11;
        bus.byte_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.byte_rdy) acc++;
            @(negedge clk);
        end
        bus.byte_vld = 1'b0;
        tests++; if (acc !== 4) begin fails++; $display("FAIL full_accepted: got %0d want 4", acc); end
        tests++; if (bus.byte_rdy !== 1'b0) begin fails++; $display("FAIL full_rdy: got %b want 0", bus.byte_rdy); end
        pulse_start();
        @(negedge clk);
        tests++; if (bus.byte_rdy !== 1'b0) begin fails++; $display("FAIL pop_same_cycle_rdy: got %b want 0", bus.byte_rdy); end
        @(negedge clk);
        tests++; if (bus.byte_rdy !== 1'b1) begin fails++; $display("FAIL pop_next_rdy: got %b want 1", bus.byte_rdy); end
    endtask

    task automatic test_reset_mid_frame();
        run_ones_frame(50);
        run_ones_frame(0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.byte_vld = 1'b0;
        bus.byte_dat = 8'h00;
        test_reset();
        test_all_ones();
        test_pattern();
        test_underrun();
        test_fifo_full();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
